// File: rtl/tx_vc_scheduler.sv
// tx_vc_scheduler: bring-up sequencing, round-robin drain of four source
// FIFOs and MSB-based routing into four destination FIFOs.
//
// state   | meaning
// RESET   | post-reset, waiting for init
// INIT    | init held: thresholds latched, pointer and error cleared
// IDLE    | configured, nothing popped or in flight
// ACTIVE  | popping sources and/or words still in the two-stage pipeline
module tx_vc_scheduler #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [3:0]              umbral_src_in,
    input  logic [3:0]              umbral_dst_in,
    input  logic [3:0]              src_empty,
    input  logic [4*DATA_WIDTH-1:0] src_data,
    input  logic [3:0]              dst_almost_full,
    input  logic [3:0]              dst_full,
    output logic [3:0]              src_pop,
    output logic [3:0]              dst_push,
    output logic [DATA_WIDTH-1:0]   dst_data,
    output logic [3:0]              umbral_src,
    output logic [3:0]              umbral_dst,
    output logic [1:0]              state,
    output logic                    idle_out,
    output logic                    error_out
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            rr_q, rr_d;
    logic [3:0]            src_pop_q, src_pop_d;
    logic [1:0]            pop_idx_q, pop_idx_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [1:0]            s1_idx_q, s1_idx_d;
    logic [3:0]            dst_push_q, dst_push_d;
    logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
    logic [3:0]            umbral_src_q, umbral_src_d;
    logic [3:0]            umbral_dst_q, umbral_dst_d;
    logic                  error_q, error_d;
    logic                  idle_q, idle_d;

    logic                  run_ok;
    logic [3:0]            eligible;
    logic                  grant_valid;
    logic [1:0]            grant_idx;
    logic [1:0]            cand;
    logic [DATA_WIDTH-1:0] s1_word;
    logic [1:0]            s1_dest;
    logic                  drop;

    // Round-robin arbiter; a source granted last cycle is masked because its
    // empty flag has not yet reflected that pop.
    always_comb begin
        run_ok      = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) && !init
                      && (dst_almost_full == 4'b0000);
        eligible    = run_ok ? (~src_empty & ~src_pop_q) : 4'b0000;
        grant_valid = 1'b0;
        grant_idx   = rr_q;
        cand        = rr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_q + 2'(i);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pop/capture pipeline: pop at t, source data valid after t+1, push at t+2.
    always_comb begin
        s1_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (s1_idx_q == 2'(k)) begin
                s1_word = src_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        s1_dest    = s1_word[DATA_WIDTH-1 -: 2];
        drop       = s1_valid_q && dst_full[s1_dest];
        dst_push_d = (s1_valid_q && !drop) ? (4'b0001 << s1_dest) : 4'b0000;
        dst_data_d = s1_valid_q ? s1_word : dst_data_q;
        s1_valid_d = (src_pop_q != 4'b0000);
        s1_idx_d   = pop_idx_q;
        src_pop_d  = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
        pop_idx_d  = grant_valid ? grant_idx : pop_idx_q;
    end

    // Bring-up FSM next state plus configuration, pointer and error updates.
    always_comb begin
        state_d      = state_q;
        rr_d         = grant_valid ? grant_idx : rr_q;
        umbral_src_d = umbral_src_q;
        umbral_dst_d = umbral_dst_q;
        error_d      = error_q;
        case (state_q)
            ST_RESET: begin
                if (init) state_d = ST_INIT;
            end
            ST_INIT: begin
                umbral_src_d = umbral_src_in;
                umbral_dst_d = (umbral_dst_in < 4'd2) ? 4'd2 : umbral_dst_in;
                rr_d         = 2'd3;
                error_d      = 1'b0;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)             state_d = ST_INIT;
                else if (grant_valid) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (!grant_valid && (src_pop_q == 4'b0000) && !s1_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase
        // A drop that lands during INIT is still reported.
        if (drop) error_d = 1'b1;
        idle_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RESET;
            rr_q         <= 2'd3;
            src_pop_q    <= 4'b0000;
            pop_idx_q    <= 2'd0;
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= 2'd0;
            dst_push_q   <= 4'b0000;
            dst_data_q   <= '0;
            umbral_src_q <= 4'd0;
            umbral_dst_q <= 4'd0;
            error_q      <= 1'b0;
            idle_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            src_pop_q    <= src_pop_d;
            pop_idx_q    <= pop_idx_d;
            s1_valid_q   <= s1_valid_d;
            s1_idx_q     <= s1_idx_d;
            dst_push_q   <= dst_push_d;
            dst_data_q   <= dst_data_d;
            umbral_src_q <= umbral_src_d;
            umbral_dst_q <= umbral_dst_d;
            error_q      <= error_d;
            idle_q       <= idle_d;
        end
    end

    assign src_pop    = src_pop_q;
    assign dst_push   = dst_push_q;
    assign dst_data   = dst_data_q;
    assign umbral_src = umbral_src_q;
    assign umbral_dst = umbral_dst_q;
    assign state      = state_q;
    assign idle_out   = idle_q;
    assign error_out  = error_q;

endmodule

// File: tb/tb_tx_vc_scheduler.sv
// Bench for tx_vc_scheduler: source FIFO environment, queue-based reference
// model, per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_tx_vc_scheduler;
    localparam int DW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            init;
    logic [3:0]      umbral_src_in, umbral_dst_in;
    logic [3:0]      src_empty_r;
    logic [DW-1:0]   src_word [4];
    logic [4*DW-1:0] src_data;
    logic [3:0]      dst_almost_full, dst_full;
    logic [3:0]      src_pop, dst_push;
    logic [DW-1:0]   dst_data;
    logic [3:0]      umbral_src, umbral_dst;
    logic [1:0]      state;
    logic            idle_out, error_out;

    always #5 clk = ~clk;

    assign src_data = {src_word[3], src_word[2], src_word[1], src_word[0]};

    tx_vc_scheduler #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_src_in(umbral_src_in), .umbral_dst_in(umbral_dst_in),
        .src_empty(src_empty_r), .src_data(src_data),
        .dst_almost_full(dst_almost_full), .dst_full(dst_full),
        .src_pop(src_pop), .dst_push(dst_push), .dst_data(dst_data),
        .umbral_src(umbral_src), .umbral_dst(umbral_dst),
        .state(state), .idle_out(idle_out), .error_out(error_out)
    );

    // environment source FIFOs
    logic [DW-1:0] src_q [4][$];
    bit            pop_empty_seen;
    int            cyc;

    // reference model: words in flight with the edge at which they land
    typedef struct packed {
        int            due;
        logic [DW-1:0] word;
    } flight_t;
    flight_t fl[$];
    flight_t cur, nf;
    logic [1:0]    m_state;
    int            m_rr, m_prev, mg, mk;
    bit            busy, dropped;
    logic [3:0]    exp_pop, exp_push, exp_usrc, exp_udst;
    logic [DW-1:0] exp_data;
    logic          exp_err, exp_idle;

    typedef struct packed {
        int            cyc;
        logic [3:0]    v;
        logic [DW-1:0] d;
    } ev_t;
    ev_t pop_log[$], push_log[$];

    int total, bad;

    // Model step on each edge (pre-edge inputs), then environment response.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_state = 2'd0; m_rr = 3; m_prev = -1; fl.delete();
            exp_pop = '0; exp_push = '0; exp_data = '0; exp_usrc = '0;
            exp_udst = '0; exp_err = 1'b0; exp_idle = 1'b0;
        end else begin
            busy = (fl.size() != 0);
            exp_push = 4'b0000;
            dropped = 1'b0;
            if (fl.size() != 0 && fl[0].due == cyc) begin
                cur = fl.pop_front();
                exp_data = cur.word;
                if (dst_full[cur.word[DW-1 -: 2]]) dropped = 1'b1;
                else exp_push = 4'b0001 << cur.word[DW-1 -: 2];
            end
            mg = -1;
            if ((m_state == 2'd2 || m_state == 2'd3) && !init && dst_almost_full == 4'b0000) begin
                for (int i = 1; i <= 4; i++) begin
                    mk = (m_rr + i) % 4;
                    if (mg < 0 && !src_empty_r[mk] && mk != m_prev) mg = mk;
                end
            end
            exp_pop = 4'b0000;
            if (mg >= 0) begin
                exp_pop = 4'b0001 << mg;
                nf.due  = cyc + 2;
                nf.word = (src_q[mg].size() != 0) ? src_q[mg][0] : '0;
                fl.push_back(nf);
            end
            m_prev = mg;
            if (m_state == 2'd1) begin
                exp_usrc = umbral_src_in;
                exp_udst = (umbral_dst_in < 4'd2) ? 4'd2 : umbral_dst_in;
                m_rr = 3;
                exp_err = 1'b0;
            end else if (mg >= 0) begin
                m_rr = mg;
            end
            if (dropped) exp_err = 1'b1;
            case (m_state)
                2'd0: if (init) m_state = 2'd1;
                2'd1: if (!init) m_state = 2'd2;
                2'd2: if (init) m_state = 2'd1; else if (mg >= 0) m_state = 2'd3;
                default: if (init) m_state = 2'd1; else if (mg < 0 && !busy) m_state = 2'd2;
            endcase
            exp_idle = (m_state == 2'd2);
        end
        for (int k = 0; k < 4; k++) begin
            if (src_pop[k]) begin
                if (src_q[k].size() == 0) pop_empty_seen = 1'b1;
                else src_word[k] <= src_q[k].pop_front();
            end
            src_empty_r[k] <= (src_q[k].size() == 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Advance n cycles, comparing every output with the model at each negedge.
    task automatic tick(input int n);
        ev_t e;
        repeat (n) begin
            @(negedge clk);
            check("state",      32'(state),      32'(m_state));
            check("idle_out",   32'(idle_out),   32'(exp_idle));
            check("src_pop",    32'(src_pop),    32'(exp_pop));
            check("dst_push",   32'(dst_push),   32'(exp_push));
            check("dst_data",   32'(dst_data),   32'(exp_data));
            check("error_out",  32'(error_out),  32'(exp_err));
            check("umbral_src", 32'(umbral_src), 32'(exp_usrc));
            check("umbral_dst", 32'(umbral_dst), 32'(exp_udst));
            check("pop_on_empty", 32'(pop_empty_seen), 32'd0);
            if (src_pop != 4'b0000) begin
                e.cyc = cyc; e.v = src_pop; e.d = '0; pop_log.push_back(e);
            end
            if (dst_push != 4'b0000) begin
                e.cyc = cyc; e.v = dst_push; e.d = dst_data; push_log.push_back(e);
            end
        end
    endtask

    task automatic load(input int k, input logic [DW-1:0] w);
        src_q[k].push_back(w);
    endtask

    function automatic int count_between(input bit use_push, input int c0, input int c1);
        int n = 0;
        if (use_push) begin
            foreach (push_log[i]) if (push_log[i].cyc > c0 && push_log[i].cyc <= c1) n++;
        end else begin
            foreach (pop_log[i]) if (pop_log[i].cyc > c0 && pop_log[i].cyc <= c1) n++;
        end
        return n;
    endfunction

    initial begin
        logic [3:0]    rr_pop [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [DW-1:0] rr_data [4] = '{6'h00, 6'h11, 6'h22, 6'h33};
        int mark, mark2;

        reset = 1'b1; init = 1'b0;
        umbral_src_in = 4'd0; umbral_dst_in = 4'd0;
        dst_almost_full = 4'b0000; dst_full = 4'b0000;
        tick(2);
        check("reset_state", 32'(state), 32'd0);
        reset = 1'b0;

        // bring-up with a sub-minimum almost-full threshold
        init = 1'b1; umbral_src_in = 4'd2; umbral_dst_in = 4'd1;
        tick(1);
        check("bringup_init", 32'(state), 32'd1);
        tick(2);
        init = 1'b0;
        tick(1);
        check("bringup_idle", 32'(state), 32'd2);
        check("bringup_usrc", 32'(umbral_src), 32'd2);
        check("bringup_udst", 32'(umbral_dst), 32'd2);
        check("bringup_nopush", 32'(push_log.size() + pop_log.size()), 32'd0);

        // round-robin across all four sources
        pop_log.delete(); push_log.delete();
        for (int k = 0; k < 4; k++) begin
            load(k, DW'((k << 4) | k));
            load(k, DW'((k << 4) | k));
        end
        tick(16);
        check("rr_pops", 32'(pop_log.size()), 32'd8);
        check("rr_pushes", 32'(push_log.size()), 32'd8);
        for (int i = 0; i < 5; i++) begin
            if (i < pop_log.size()) begin
                check("rr_pop_val", 32'(pop_log[i].v), 32'(rr_pop[i]));
                if (i > 0) check("rr_pop_gap", 32'(pop_log[i].cyc - pop_log[i-1].cyc), 32'd1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < push_log.size()) begin
                check("rr_push_val", 32'(push_log[i].v), 32'(rr_pop[i]));
                check("rr_push_data", 32'(push_log[i].d), 32'(rr_data[i]));
            end
        end
        if (push_log.size() > 0 && pop_log.size() > 0)
            check("rr_latency", 32'(push_log[0].cyc - pop_log[0].cyc), 32'd2);
        check("rr_back_idle", 32'(state), 32'd2);

        // single source: one pop every other cycle
        pop_log.delete(); push_log.delete();
        load(2, 6'h25); load(2, 6'h0A); load(2, 6'h3F);
        tick(14);
        check("single_pops", 32'(pop_log.size()), 32'd3);
        check("single_pushes", 32'(push_log.size()), 32'd3);
        for (int i = 1; i < 3; i++) begin
            if (i < pop_log.size())
                check("single_gap", 32'(pop_log[i].cyc - pop_log[i-1].cyc), 32'd2);
        end
        if (push_log.size() == 3) check("single_last", 32'(push_log[2].v), 32'b1000);
        check("single_idle", 32'(state), 32'd2);

        // backpressure mid-stream
        pop_log.delete(); push_log.delete();
        for (int w = 0; w < 4; w++) begin
            load(0, DW'((w << 4) | (w + 1)));
            load(1, DW'((w << 4) | (w + 5)));
        end
        tick(4);
        dst_almost_full = 4'b0010;
        mark = cyc;
        tick(6);
        mark2 = cyc;
        check("bp_no_pop", 32'(count_between(1'b0, mark, mark2)), 32'd0);
        check("bp_inflight", 32'(count_between(1'b1, mark, mark2)), 32'd2);
        dst_almost_full = 4'b0000;
        tick(20);
        check("bp_total_push", 32'(push_log.size()), 32'd8);

        // drop to a full destination
        pop_log.delete(); push_log.delete();
        dst_full = 4'b1000;
        load(0, 6'h30);
        tick(6);
        check("drop_err", 32'(error_out), 32'd1);
        check("drop_nopush", 32'(push_log.size()), 32'd0);
        dst_full = 4'b0000;
        load(1, 6'h05);
        tick(6);
        check("drop_sticky", 32'(error_out), 32'd1);
        check("drop_next_push", 32'(push_log.size()), 32'd1);

        // init during ACTIVE
        pop_log.delete(); push_log.delete();
        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 3; w++) load(k, DW'((k << 4) | (w + 8)));
        tick(3);
        init = 1'b1;
        mark = cyc;
        tick(1);
        check("mid_init_state", 32'(state), 32'd1);
        tick(3);
        check("mid_init_err", 32'(error_out), 32'd0);
        check("mid_init_push", 32'(count_between(1'b1, mark, cyc)), 32'd2);
        check("mid_init_nopop", 32'(count_between(1'b0, mark, cyc)), 32'd0);
        init = 1'b0;
        tick(6);

        // reset during ACTIVE
        reset = 1'b1;
        tick(1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({src_pop, dst_push, dst_data, error_out, idle_out}), 32'd0);
        check("rst_umbral", 32'({umbral_src, umbral_dst}), 32'd0);
        reset = 1'b0;

        // second bring-up, then drain what is left
        init = 1'b1; umbral_src_in = 4'd9; umbral_dst_in = 4'd7;
        tick(2);
        init = 1'b0;
        tick(1);
        check("rebring_state", 32'(state), 32'd2);
        check("rebring_usrc", 32'(umbral_src), 32'd9);
        check("rebring_udst", 32'(umbral_dst), 32'd7);
        tick(40);
        check("drained", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'd0);
        check("end_idle", 32'(state), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_vc_scheduler.md
# tx_vc_scheduler

Scheduler and configuration controller for the transmit-layer FIFO bank. It owns the bring-up sequence: RESET, then threshold load on `init`, then run. It drains four source FIFOs round-robin and routes each word by its two MSBs to one of four destination FIFOs of the D1 type. It throttles new reads whenever any destination reports almost-full, and it drives the threshold (Umbral) inputs of both FIFO ranks.

## Interface
Parameters:
- `DATA_WIDTH`, default 6: word width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] select the destination.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `init`  in  1  configuration request; high = load thresholds and hold.
- `umbral_src_in`  in  4  almost-empty threshold for source FIFOs.
- `umbral_dst_in`  in  4  almost-full threshold for destination FIFOs.
- `src_empty`  in  4  empty flags of source FIFOs 0..3.
- `src_data`  in  4*DATA_WIDTH  registered source read data; source k on bits [k*DATA_WIDTH +: DATA_WIDTH].
- `dst_almost_full`  in  4  destination almost-full flags.
- `dst_full`  in  4  destination full flags.
- `src_pop`  out  4  one-hot read enable to sources.
- `dst_push`  out  4  one-hot write enable to destinations.
- `dst_data`  out  DATA_WIDTH  word written to destinations.
- `umbral_src`  out  4  latched source threshold.
- `umbral_dst`  out  4  latched destination threshold, never below 2.
- `state`  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- `idle_out`  out  1  high when `state`=IDLE.
- `error_out`  out  1  sticky drop indicator.

## Operation
- All outputs are registered.
- Reset values: every output is 0, `state`=RESET, and the round-robin pointer is 3, so source 0 has first priority.
- State transitions:
  - RESET goes to INIT when `init`=1.
  - INIT stays in INIT while `init`=1. Each cycle in INIT latches `umbral_src`<=`umbral_src_in` and `umbral_dst`<=max(`umbral_dst_in`,2), sets the RR pointer to 3 and clears `error_out`. INIT goes to IDLE when `init`=0.
  - IDLE goes to ACTIVE when some source is eligible.
  - ACTIVE goes to IDLE when no pop is issued this cycle and the pipeline holds no words.
  - IDLE or ACTIVE goes to INIT on `init`=1. No new pops are issued after that; words already in flight still complete their push.
- Eligibility for source k requires all of:
  - `src_empty[k]`=0;
  - k was not granted on the previous cycle, because the source's empty flag lags its own pop by one edge;
  - `dst_almost_full`=4'b0000;
  - state is IDLE or ACTIVE and `init`=0.
- Arbitration:
  - Grant the first eligible index after the RR pointer, wrapping 3 to 0.
  - Drive `src_pop`<=onehot(grant) and set the pointer to the grant.
  - If nothing is eligible, `src_pop`<=0 and the pointer is unchanged.
- Routing: the source presents `src_data[g]` one cycle after the pop. The scheduler then sets `dst_data`<=that word and `dst_push`<=onehot(word[DATA_WIDTH-1:DATA_WIDTH-2]).
- Drop rule: if the selected `dst_full` bit is 1 when the word is captured, the push is suppressed (`dst_push`=0) and `error_out`<=1. `error_out` stays set until reset or INIT.
- At most 2 words are in flight. An almost-full threshold of 2 or more guarantees no drop under legal flow.

## Timing
- Pop-to-push latency is 2 cycles:
  - edge t: `src_pop` asserted;
  - edge t+1: the source updates its data;
  - edge t+2: `dst_push` and `dst_data` asserted for one cycle.
- Throughput is 1 word/cycle with two or more non-empty sources. A single source gets at most 1 word per 2 cycles, because of the previous-grant mask.
- An almost-full flag seen at edge t blocks pops from edge t onward. The 2 in-flight words still push.
- `idle_out` and `state` update on the same edge as the transition.
- `reset` overrides `init` and everything else. An in-flight word is discarded on reset.
- `dst_push` and `src_pop` are never multi-hot. `dst_push` is 0 whenever no captured word is valid.

## Test plan
- Bring-up:
  - Stimulus: `reset`=1 for 2 cycles; `init`=1 for 3 cycles with `umbral_src_in`=2, `umbral_dst_in`=1; then `init`=0.
  - Response: `state` goes 0→1→2. `umbral_src`=2, `umbral_dst`=2. All pops and pushes stay 0 throughout.
- Round-robin with all sources holding data:
  - Stimulus: each source k has data {k[1:0],4'hk}.
  - Response: `src_pop` goes 0001, 0010, 0100, 1000, 0001 on consecutive cycles. `dst_push` follows 2 cycles later: 0001, 0010, 0100, 1000 with `dst_data`=0x00, 0x11, 0x22, 0x33.
- Single source:
  - Stimulus: only source 2 non-empty, 3 words.
  - Response: `src_pop`=0100 on alternate cycles only. Three pushes in total, then `state` returns to IDLE.
- Backpressure:
  - Stimulus: `dst_almost_full[1]`=1 mid-stream.
  - Response: no new pops from that edge. Exactly the in-flight words (≤2) are pushed, then `src_pop`=0 until the flag clears.
- Drop:
  - Stimulus: force `dst_full[3]`=1 while a word with MSBs=2'b11 is captured.
  - Response: `dst_push`=0 and `error_out`=1 from the next cycle. `error_out` clears only on INIT or reset.
- Mid-run events:
  - Stimulus: `init`=1 during ACTIVE.
  - Response: `state`=INIT next edge. Pending pushes still occur, no new pops. `error_out` is cleared.
  - Stimulus: `reset` during ACTIVE.
  - Response: all outputs are 0 next edge.
